// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter for memory port B with bounded lock; writes land one edge after accept,
// read data returns registered one edge after the address; losers stall via gnt=0.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] LIM = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                state;
  logic                  ptr;
  logic [CW-1:0]         cnt;
  logic                  rd_pend;
  logic                  rd_own;

  logic                  own0, own1, acc, win, w_we, w_lock, hold_lock;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  // ptr names the last winner, so on a tie the other side goes next
  assign r0_gnt = r0_req && !own1 && (own0 || !r1_req || ptr);
  assign r1_gnt = r1_req && !own0 && (own1 || !r0_req || !ptr);

  assign acc       = r0_gnt || r1_gnt;
  assign win       = r1_gnt;
  assign w_we      = win ? r1_we    : r0_we;
  assign w_lock    = win ? r1_lock  : r0_lock;
  assign w_addr    = win ? r1_addr  : r0_addr;
  assign w_wdata   = win ? r1_wdata : r0_wdata;
  assign hold_lock = own1 ? r1_lock : r0_lock;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      rd_own    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      mem_we  <= acc && w_we;
      rd_pend <= acc && !w_we;
      if (acc) begin
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
        ptr       <= win;
        rd_own    <= win;
      end

      // mem_rdata was driven on the falling edge for the address issued last cycle
      r0_rvalid <= rd_pend && !rd_own;
      r1_rvalid <= rd_pend && rd_own;
      if (rd_pend && !rd_own) r0_rdata <= mem_rdata;
      if (rd_pend && rd_own)  r1_rdata <= mem_rdata;

      case (state)
        IDLE: begin
          if (acc && w_lock && (cnt < LIM)) begin
            state <= win ? OWN1 : OWN0;
            cnt   <= cnt + CW'(1);
          end
        end
        default: begin
          if (hold_lock && (cnt < LIM)) begin
            cnt <= cnt + CW'(1);
          end else begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= own1;
          end
        end
      endcase
    end
  end

endmodule
